// File: rtl/bank_req_queue.sv
// Per-bank request queue: separate read and write FIFOs feeding one scheduler
// port, with a two-mode arbiter that drains writes between watermarks.
module bank_req_queue #(
  parameter int QUEUE_DEPTH = 8,
  parameter int INDEX_WIDTH = 6,
  parameter int ROW_WIDTH   = 16,
  parameter int WR_HIGH_WM  = 6,
  parameter int WR_LOW_WM   = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  input  logic                         in_type,
  input  logic [INDEX_WIDTH-1:0]       in_index,
  input  logic [ROW_WIDTH-1:0]         in_row,
  output logic                         busy_o,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic                         out_type,
  output logic [INDEX_WIDTH-1:0]       out_index,
  output logic [ROW_WIDTH-1:0]         out_row,
  output logic [$clog2(QUEUE_DEPTH):0] rd_count_o,
  output logic [$clog2(QUEUE_DEPTH):0] wr_count_o,
  output logic                         overflow_o
);

  localparam int PW = $clog2(QUEUE_DEPTH);
  localparam int CW = PW + 1;
  localparam int EW = INDEX_WIDTH + ROW_WIDTH;

  localparam logic [CW-1:0] FULL    = CW'(QUEUE_DEPTH);
  localparam logic [CW-1:0] BUSY_TH = CW'(QUEUE_DEPTH - 1);
  localparam logic [CW-1:0] HIGH_WM = CW'(WR_HIGH_WM);
  localparam logic [CW-1:0] LOW_WM  = CW'(WR_LOW_WM);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [PW-1:0] PTR_ONE = PW'(1);

  typedef enum logic {
    RD_MODE  = 1'b0,
    WR_DRAIN = 1'b1
  } state_t;

  state_t        state;
  state_t        state_nxt;

  logic [EW-1:0] rd_mem [QUEUE_DEPTH];
  logic [EW-1:0] wr_mem [QUEUE_DEPTH];

  logic [PW-1:0] rd_wp;
  logic [PW-1:0] rd_rp;
  logic [PW-1:0] wr_wp;
  logic [PW-1:0] wr_rp;
  logic [CW-1:0] rd_count;
  logic [CW-1:0] wr_count;
  logic [CW-1:0] rd_count_nxt;
  logic [CW-1:0] wr_count_nxt;

  logic          rd_full;
  logic          wr_full;
  logic          xfer;
  logic          rd_pop;
  logic          wr_pop;
  logic          rd_push_req;
  logic          wr_push_req;
  logic          rd_push;
  logic          wr_push;
  logic          drop;
  logic [EW-1:0] head;

  assign rd_full = (rd_count == FULL);
  assign wr_full = (wr_count == FULL);

  assign out_valid = (state == RD_MODE) ? (rd_count != '0) : (wr_count != '0);
  assign xfer      = out_valid && out_ready;
  assign rd_pop    = xfer && (state == RD_MODE);
  assign wr_pop    = xfer && (state == WR_DRAIN);

  // A push into a full FIFO is only legal when the same FIFO frees a slot this edge.
  assign rd_push_req = in_valid && !in_type;
  assign wr_push_req = in_valid && in_type;
  assign rd_push     = rd_push_req && (!rd_full || rd_pop);
  assign wr_push     = wr_push_req && (!wr_full || wr_pop);
  assign drop        = (rd_push_req && !rd_push) || (wr_push_req && !wr_push);

  // Fields are gated by out_valid so an idle or reset queue presents zeros.
  assign head      = (state == WR_DRAIN) ? wr_mem[wr_rp] : rd_mem[rd_rp];
  assign out_type  = out_valid && (state == WR_DRAIN);
  assign out_index = out_valid ? head[EW-1:ROW_WIDTH] : '0;
  assign out_row   = out_valid ? head[ROW_WIDTH-1:0] : '0;

  assign rd_count_o = rd_count;
  assign wr_count_o = wr_count;

  always_comb begin
    rd_count_nxt = rd_count;
    if (rd_push && !rd_pop) begin
      rd_count_nxt = rd_count + CNT_ONE;
    end else if (!rd_push && rd_pop) begin
      rd_count_nxt = rd_count - CNT_ONE;
    end
  end

  always_comb begin
    wr_count_nxt = wr_count;
    if (wr_push && !wr_pop) begin
      wr_count_nxt = wr_count + CNT_ONE;
    end else if (!wr_push && wr_pop) begin
      wr_count_nxt = wr_count - CNT_ONE;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      RD_MODE: begin
        if ((wr_count_nxt >= HIGH_WM) ||
            ((rd_count_nxt == '0) && (wr_count_nxt != '0))) begin
          state_nxt = WR_DRAIN;
        end
      end
      WR_DRAIN: begin
        if ((wr_count_nxt == '0) ||
            ((wr_count_nxt <= LOW_WM) && (rd_count_nxt != '0))) begin
          state_nxt = RD_MODE;
        end
      end
      default: state_nxt = RD_MODE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rd_push) begin
      rd_mem[rd_wp] <= {in_index, in_row};
    end
    if (wr_push) begin
      wr_mem[wr_wp] <= {in_index, in_row};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= RD_MODE;
      rd_wp      <= '0;
      rd_rp      <= '0;
      wr_wp      <= '0;
      wr_rp      <= '0;
      rd_count   <= '0;
      wr_count   <= '0;
      busy_o     <= 1'b0;
      overflow_o <= 1'b0;
    end else begin
      if (rd_push) begin
        rd_wp <= rd_wp + PTR_ONE;
      end
      if (rd_pop) begin
        rd_rp <= rd_rp + PTR_ONE;
      end
      if (wr_push) begin
        wr_wp <= wr_wp + PTR_ONE;
      end
      if (wr_pop) begin
        wr_rp <= wr_rp + PTR_ONE;
      end
      rd_count <= rd_count_nxt;
      wr_count <= wr_count_nxt;
      // Busy tracks post-update occupancy so the mapper's in-flight push still fits.
      busy_o   <= (rd_count_nxt >= BUSY_TH) || (wr_count_nxt >= BUSY_TH);
      if (drop) begin
        overflow_o <= 1'b1;
      end
      // Mode only changes when no head is being held for the scheduler.
      if (!out_valid || xfer) begin
        state <= state_nxt;
      end
    end
  end

endmodule
